// File: rtl/word_tokenizer_pkg.sv
// Shared token codes, ASCII bounds and keyword constants for the word tokenizer.
// Also holds the letter test and the word classifier used by the top level.
package word_tokenizer_pkg;

    typedef enum logic [1:0] {
        TOK_OTHER = 2'b00,
        TOK_BEGIN = 2'b01,
        TOK_END   = 2'b10,
        TOK_EOS   = 2'b11
    } tok_kind_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WORD = 1'b1
    } tok_state_e;

    localparam logic [7:0]  ASCII_A  = 8'h41;
    localparam logic [7:0]  ASCII_Z  = 8'h5A;
    localparam logic [7:0]  ASCII_a  = 8'h61;
    localparam logic [7:0]  ASCII_z  = 8'h7A;
    localparam logic [39:0] KW_BEGIN = 40'h626567696e;
    localparam logic [23:0] KW_END   = 24'h656e64;
    localparam logic [2:0]  LEN_MAX  = 3'd6;

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= ASCII_A) && (b <= ASCII_Z)) || ((b >= ASCII_a) && (b <= ASCII_z));
    endfunction

    // Saturated length 6 never matches, so over-long words fall through to OTHER.
    function automatic tok_kind_e classify_word(input logic [39:0] word, input logic [2:0] len);
        if ((len == 3'd5) && (word == KW_BEGIN)) return TOK_BEGIN;
        if ((len == 3'd3) && (word[23:0] == KW_END)) return TOK_END;
        return TOK_OTHER;
    endfunction

endpackage

// File: rtl/word_tokenizer_fifo.sv
// Small token FIFO holding {last,kind} entries between tokenizer and consumer.
// Pointers wrap naturally because DEPTH is a power of two.
module tok_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/word_tokenizer.sv
// Case-folding byte-stream tokenizer: splits words on non-letters, classifies
// them as BEGIN/END/OTHER and queues one token per word for the nesting checker.
module word_tokenizer
    import word_tokenizer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int EMIT_OTHER = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       tok_valid,
    input  logic       tok_ready,
    output logic [1:0] tok_kind,
    output logic       tok_last
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tok_state_e  state, state_next;
    logic [39:0] word_buf, buf_next, app_buf, cur_buf;
    logic [2:0]  word_len, len_next, app_len, cur_len;
    logic [7:0]  folded;
    logic        letter;
    logic        accept;
    logic        keep;
    logic        push_req;
    logic [2:0]  push_data;
    tok_kind_e   kind;

    logic [2:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign folded   = in_data | 8'h20;
    assign letter   = is_letter(in_data);
    assign in_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

    // A letter extends the current word (or starts a new one from IDLE) before any close.
    assign app_buf = (state == S_WORD) ? {word_buf[31:0], folded} : {32'b0, folded};
    assign app_len = (state == S_WORD) ? ((word_len == LEN_MAX) ? LEN_MAX : word_len + 3'd1) : 3'd1;
    assign cur_buf = letter ? app_buf : word_buf;
    assign cur_len = letter ? app_len : word_len;
    assign kind    = classify_word(cur_buf, cur_len);
    assign keep    = (kind != TOK_OTHER) || (EMIT_OTHER != 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            word_buf <= '0;
            word_len <= '0;
        end else begin
            state    <= state_next;
            word_buf <= buf_next;
            word_len <= len_next;
        end
    end

    always_comb begin
        state_next = state;
        buf_next   = word_buf;
        len_next   = word_len;
        push_req   = 1'b0;
        push_data  = '0;
        if (accept) begin
            if (in_last) begin
                // Stream end always yields exactly one token flagged last.
                push_req   = 1'b1;
                push_data  = ((letter || (state == S_WORD)) && keep) ? {1'b1, kind} : {1'b1, TOK_EOS};
                state_next = S_IDLE;
                buf_next   = '0;
                len_next   = '0;
            end else if (letter) begin
                state_next = S_WORD;
                buf_next   = app_buf;
                len_next   = app_len;
            end else if (state == S_WORD) begin
                push_req   = keep;
                push_data  = {1'b0, kind};
                state_next = S_IDLE;
                buf_next   = '0;
                len_next   = '0;
            end
        end
    end

    tok_fifo #(
        .WIDTH (3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req && !fifo_full),
        .wr_data (push_data),
        .pop     (tok_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tok_valid = !fifo_empty;
    assign tok_kind  = head[1:0];
    assign tok_last  = head[2];

endmodule

// File: tb/tb_word_tokenizer.sv
// Directed self-checking bench for word_tokenizer; a second instance with
// EMIT_OTHER=0 sees exactly the beats accepted by the main instance.
module tb_word_tokenizer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_kind;
    logic       tok_last;

    logic       in_valid0;
    logic       in_ready0;
    logic       tok_valid0;
    logic [1:0] tok_kind0;
    logic       tok_last0;

    int checks = 0;
    int errors = 0;
    logic [2:0] got_q[$];
    logic [2:0] got0_q[$];

    assign in_valid0 = in_valid && in_ready;

    word_tokenizer #(.FIFO_DEPTH(4), .EMIT_OTHER(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .tok_valid(tok_valid),
        .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_last(tok_last)
    );

    word_tokenizer #(.FIFO_DEPTH(4), .EMIT_OTHER(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .tok_valid(tok_valid0),
        .tok_ready(tok_ready), .tok_kind(tok_kind0), .tok_last(tok_last0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every popped token, sampled mid-low-phase after inputs settle.
    always begin
        @(negedge clk);
        #2;
        if (!reset && tok_ready) begin
            if (tok_valid)  got_q.push_back({tok_last, tok_kind});
            if (tok_valid0) got0_q.push_back({tok_last0, tok_kind0});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while ((in_ready !== 1'b1) && (guard < 100)) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last && (i == s.len() - 1));
    endtask

    task automatic pop_one();
        tok_ready = 1'b1;
        @(negedge clk);
        tok_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; tok_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tok_valid got %b want 0", tok_valid); end
        checks++; if (tok_kind !== 2'b00) begin errors++; $display("[TB] FAIL reset_tok_kind got %b want 00", tok_kind); end
        checks++; if (tok_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_tok_last got %b want 0", tok_last); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_full_rate();
        string s;
        logic [2:0] exp [2];
        s = "begin end ";
        exp = '{3'b001, 3'b010};
        got_q.delete();
        tok_ready = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1; in_data = s[i]; in_last = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_rate_in_ready idx=%0d got %b want 1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("[TB] FAIL full_rate_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_q.size() <= i) begin errors++; $display("[TB] FAIL full_rate_tok%0d missing want %b", i, exp[i]); end
            else if (got_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL full_rate_tok%0d got %b want %b", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_case_fold();
        logic [2:0] exp [2];
        exp = '{3'b001, 3'b010};
        got_q.delete();
        tok_ready = 1'b1;
        send_str("BeGiN;End\n", 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("[TB] FAIL fold_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_q.size() <= i) begin errors++; $display("[TB] FAIL fold_tok%0d missing want %b", i, exp[i]); end
            else if (got_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL fold_tok%0d got %b want %b", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_other_words();
        got_q.delete();
        got0_q.delete();
        tok_ready = 1'b1;
        send_str("beginx en endd ", 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 3) begin errors++; $display("[TB] FAIL other_count got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q.size() <= i) begin errors++; $display("[TB] FAIL other_tok%0d missing want 000", i); end
            else if (got_q[i] !== 3'b000) begin errors++; $display("[TB] FAIL other_tok%0d got %b want 000", i, got_q[i]); end
        end
        checks++;
        if (got0_q.size() !== 0) begin errors++; $display("[TB] FAIL other_dropped_count got %0d want 0", got0_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp [5];
        exp = '{3'b001, 3'b010, 3'b000, 3'b010, 3'b000};
        got_q.delete();
        tok_ready = 1'b0;
        send_str("begin end a end ", 1'b0);
        in_valid = 1'b1; in_data = "e"; in_last = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_in_ready got %b want 0", in_ready); end
        checks++; if ({tok_valid, tok_last, tok_kind} !== 4'b1001) begin errors++; $display("[TB] FAIL bp_head got %b want 1001", {tok_valid, tok_last, tok_kind}); end
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_in_ready got %b want 0", in_ready); end
        checks++; if ({tok_valid, tok_last, tok_kind} !== 4'b1001) begin errors++; $display("[TB] FAIL bp_head_stable got %b want 1001", {tok_valid, tok_last, tok_kind}); end
        pop_one();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_after_pop_in_ready got %b want 1", in_ready); end
        send_byte("e", 1'b0);
        send_byte(" ", 1'b0);
        tok_ready = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (got_q.size() !== 5) begin errors++; $display("[TB] FAIL bp_count got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_q.size() <= i) begin errors++; $display("[TB] FAIL bp_tok%0d missing want %b", i, exp[i]); end
            else if (got_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL bp_tok%0d got %b want %b", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_last();
        tok_ready = 1'b0;
        send_str("end", 1'b1);
        checks++; if ({tok_valid, tok_last, tok_kind} !== 4'b1110) begin errors++; $display("[TB] FAIL last_end got %b want 1110", {tok_valid, tok_last, tok_kind}); end
        checks++; if ({tok_valid0, tok_last0, tok_kind0} !== 4'b1110) begin errors++; $display("[TB] FAIL last_end_drop got %b want 1110", {tok_valid0, tok_last0, tok_kind0}); end
        pop_one();
        send_byte(" ", 1'b1);
        checks++; if ({tok_valid, tok_last, tok_kind} !== 4'b1111) begin errors++; $display("[TB] FAIL last_eos got %b want 1111", {tok_valid, tok_last, tok_kind}); end
        pop_one();
        send_str("xyz", 1'b1);
        checks++; if ({tok_valid, tok_last, tok_kind} !== 4'b1100) begin errors++; $display("[TB] FAIL last_other got %b want 1100", {tok_valid, tok_last, tok_kind}); end
        checks++; if ({tok_valid0, tok_last0, tok_kind0} !== 4'b1111) begin errors++; $display("[TB] FAIL last_other_drop got %b want 1111", {tok_valid0, tok_last0, tok_kind0}); end
        tok_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("[TB] FAIL last_drained got %b want 0", tok_valid); end
    endtask

    task automatic test_reset_mid_word();
        tok_ready = 1'b0;
        send_str("a b beg", 1'b0);
        checks++; if (tok_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_queued got %b want 1", tok_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_tok_valid got %b want 0", tok_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready got %b want 1", in_ready); end
        got_q.delete();
        tok_ready = 1'b1;
        send_str("end ", 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== 1) begin errors++; $display("[TB] FAIL rst_mid_count got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 3'b010) begin errors++; $display("[TB] FAIL rst_mid_tok got %b want 010", got_q[0]); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_case_fold();
        test_other_words();
        test_back_to_back();
        test_last();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
